// File: rtl/mips32_lane_ram.sv
// Byte-lane block RAM with one read and one write port, optional post-reset
// zero fill, optional same-address write-to-read bypass and optional output register.
module mips32_lane_ram #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32,
  parameter int LANES  = 4,
  parameter int OUTREG = 0,
  parameter int CLEAR  = 1,
  parameter int BYPASS = 1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              ready,
  input  logic              rdReq,
  input  logic [AWIDTH-1:0] rdAddr,
  output logic [DWIDTH-1:0] rdData,
  output logic              rdValid,
  input  logic              wrReq,
  input  logic [AWIDTH-1:0] wrAddr,
  input  logic [DWIDTH-1:0] wrData,
  input  logic [LANES-1:0]  wrLane
);

  // state    | meaning
  // ST_CLEAR | zero fill in progress, one word per cycle, ready=0
  // ST_RUN   | normal traffic, ready=1 from the cycle after entry
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam int                LW        = (LANES == 1) ? DWIDTH : 8;
  localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

  logic [DWIDTH-1:0] r_mem [0:(1<<AWIDTH)-1];

  logic [0:0]        r_state;
  logic [AWIDTH-1:0] r_cnt;
  logic              r_ready;

  logic              w_clr_act;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_byp_hit;
  logic [LANES-1:0]  w_lane_en;
  logic [LANES-1:0]  w_we_lane;
  logic [AWIDTH-1:0] w_waddr;
  logic [DWIDTH-1:0] w_wdata;
  logic [DWIDTH-1:0] w_wmask;
  logic [DWIDTH-1:0] w_word;

  logic [DWIDTH-1:0] r_q;
  logic [DWIDTH-1:0] r_byp_data;
  logic [DWIDTH-1:0] r_byp_mask;
  logic              r_v1;

  assign w_clr_act = reset && (r_state == ST_CLEAR);
  assign w_wr_fire = reset && r_ready && wrReq;
  assign w_rd_fire = reset && r_ready && rdReq;

  generate
    if (LANES == 1) begin : g_word
      logic w_unused_lane;
      assign w_unused_lane = ^wrLane;
      assign w_lane_en     = w_wr_fire;
    end else begin : g_lanes
      assign w_lane_en = wrLane & {LANES{w_wr_fire}};
    end
    for (genvar g = 0; g < LANES; g++) begin : g_mask
      assign w_wmask[g*LW +: LW] = {LW{w_lane_en[g]}};
    end
  endgenerate

  // The clear engine borrows the single write port; ready=0 keeps user writes off it.
  assign w_we_lane = w_clr_act ? {LANES{1'b1}} : w_lane_en;
  assign w_waddr   = w_clr_act ? r_cnt : wrAddr;
  assign w_wdata   = w_clr_act ? '0 : wrData;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= (CLEAR != 0) ? ST_CLEAR : ST_RUN;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        default: r_ready <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_we_lane[i]) r_mem[w_waddr][i*LW +: LW] <= w_wdata[i*LW +: LW];
    end
  end

  // Array output is the pre-write word; bypassed lanes are merged after the array.
  assign w_byp_hit = (BYPASS != 0) && w_wr_fire && (wrAddr == rdAddr);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_q        <= '0;
      r_byp_data <= '0;
      r_byp_mask <= '0;
      r_v1       <= 1'b0;
    end else begin
      r_v1 <= w_rd_fire;
      if (w_rd_fire) begin
        r_q        <= r_mem[rdAddr];
        r_byp_data <= wrData;
        r_byp_mask <= w_byp_hit ? w_wmask : '0;
      end
    end
  end

  assign w_word = (r_q & ~r_byp_mask) | (r_byp_data & r_byp_mask);

  generate
    if (OUTREG != 0) begin : g_outreg
      logic [DWIDTH-1:0] r_out;
      logic              r_v2;
      always_ff @(posedge clock) begin
        if (!reset) begin
          r_out <= '0;
          r_v2  <= 1'b0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_out <= w_word;
        end
      end
      assign rdData  = r_out;
      assign rdValid = r_v2;
    end else begin : g_direct
      assign rdData  = w_word;
      assign rdValid = r_v1;
    end
  endgenerate

  assign ready = r_ready;

endmodule

// File: tb/tb_mips32_lane_ram.sv
// Directed bench for mips32_lane_ram: two instances share stimulus, one with
// latency 1 + bypass (A), one with latency 2 and no bypass (B).
module tb_mips32_lane_ram;

  logic        clock = 1'b0;
  logic        reset;
  logic        rdReq;
  logic [3:0]  rdAddr;
  logic        wrReq;
  logic [3:0]  wrAddr;
  logic [31:0] wrData;
  logic [3:0]  wrLane;

  logic        readyA, rdValidA, readyB, rdValidB;
  logic [31:0] rdDataA, rdDataB;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  mips32_lane_ram #(.AWIDTH(4), .DWIDTH(32), .LANES(4), .OUTREG(0), .CLEAR(1), .BYPASS(1)) u_dut_a (
    .clock(clock), .reset(reset), .ready(readyA),
    .rdReq(rdReq), .rdAddr(rdAddr), .rdData(rdDataA), .rdValid(rdValidA),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrLane(wrLane)
  );

  mips32_lane_ram #(.AWIDTH(4), .DWIDTH(32), .LANES(4), .OUTREG(1), .CLEAR(1), .BYPASS(0)) u_dut_b (
    .clock(clock), .reset(reset), .ready(readyB),
    .rdReq(rdReq), .rdAddr(rdAddr), .rdData(rdDataB), .rdValid(rdValidB),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrLane(wrLane)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rdReq  = 1'b0;
    wrReq  = 1'b0;
    wrLane = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] l);
    wrReq  = 1'b1;
    wrAddr = a;
    wrData = d;
    wrLane = l;
    cyc();
    wrReq  = 1'b0;
  endtask

  task automatic issue_rd(input logic [3:0] a);
    rdReq  = 1'b1;
    rdAddr = a;
    cyc();
    rdReq  = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    idle();
    repeat (3) cyc();
    n_cmp++;
    if ({readyA, rdValidA, rdDataA, readyB, rdValidB, rdDataB} !== 68'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdyA=%b vA=%b dA=%h rdyB=%b vB=%b dB=%h want all zero",
               readyA, rdValidA, rdDataA, readyB, rdValidB, rdDataB);
    end
    reset = 1'b1;
    n = 0;
    while (readyA !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    n_cmp++;
    if (n !== 16) begin
      n_bad++;
      $display("FAIL clear_ready_cycles: got %0d want 16", n);
    end
    n_cmp++;
    if (readyB !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_readyB: got %b want 1", readyB);
    end
  endtask

  task automatic test_clear();
    logic expA, expB;
    for (int i = 0; i < 19; i++) begin
      rdReq  = (i < 16);
      rdAddr = 4'(i);
      cyc();
      expA = (i < 16);
      expB = (i >= 1 && i <= 16);
      n_cmp++;
      if ({rdValidA, rdDataA} !== {expA, 32'h0}) begin
        n_bad++;
        $display("FAIL clear_readA[%0d]: got v=%b d=%h want v=%b d=0", i, rdValidA, rdDataA, expA);
      end
      n_cmp++;
      if ({rdValidB, rdDataB} !== {expB, 32'h0}) begin
        n_bad++;
        $display("FAIL clear_readB[%0d]: got v=%b d=%h want v=%b d=0", i, rdValidB, rdDataB, expB);
      end
    end
    rdReq = 1'b0;
  endtask

  task automatic test_full_write();
    wr(4'd5, 32'hDEADBEEF, 4'b1111);
    issue_rd(4'd5);
    n_cmp++;
    if ({rdValidA, rdDataA, rdValidB} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      n_bad++;
      $display("FAIL full_wr_n1: got vA=%b dA=%h vB=%b want vA=1 dA=deadbeef vB=0", rdValidA, rdDataA, rdValidB);
    end
    cyc();
    n_cmp++;
    if ({rdValidA, rdDataA, rdValidB, rdDataB} !== {1'b0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL full_wr_n2: got vA=%b dA=%h vB=%b dB=%h want 0/deadbeef 1/deadbeef",
               rdValidA, rdDataA, rdValidB, rdDataB);
    end
    cyc();
    n_cmp++;
    if ({rdValidB, rdDataB} !== {1'b0, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL full_wr_holdB: got vB=%b dB=%h want 0/deadbeef", rdValidB, rdDataB);
    end
  endtask

  task automatic test_partial_lanes();
    wr(4'd5, 32'h0000AA00, 4'b0010);
    issue_rd(4'd5);
    n_cmp++;
    if ({rdValidA, rdDataA} !== {1'b1, 32'hDEADAAEF}) begin
      n_bad++;
      $display("FAIL lane1_A: got v=%b d=%h want 1/deadaaef", rdValidA, rdDataA);
    end
    cyc();
    n_cmp++;
    if ({rdValidB, rdDataB} !== {1'b1, 32'hDEADAAEF}) begin
      n_bad++;
      $display("FAIL lane1_B: got v=%b d=%h want 1/deadaaef", rdValidB, rdDataB);
    end
    wr(4'd5, 32'hFFFFFFFF, 4'b0000);
    issue_rd(4'd5);
    n_cmp++;
    if ({rdValidA, rdDataA} !== {1'b1, 32'hDEADAAEF}) begin
      n_bad++;
      $display("FAIL lane0_A: got v=%b d=%h want 1/deadaaef", rdValidA, rdDataA);
    end
    cyc();
    n_cmp++;
    if ({rdValidB, rdDataB} !== {1'b1, 32'hDEADAAEF}) begin
      n_bad++;
      $display("FAIL lane0_B: got v=%b d=%h want 1/deadaaef", rdValidB, rdDataB);
    end
  endtask

  task automatic test_bypass();
    wrReq = 1'b1; wrAddr = 4'd5; wrData = 32'h11223344; wrLane = 4'b1001;
    rdReq = 1'b1; rdAddr = 4'd5;
    cyc();
    idle();
    n_cmp++;
    if ({rdValidA, rdDataA} !== {1'b1, 32'h11ADAA44}) begin
      n_bad++;
      $display("FAIL bypass_on: got v=%b d=%h want 1/11adaa44", rdValidA, rdDataA);
    end
    cyc();
    n_cmp++;
    if ({rdValidB, rdDataB} !== {1'b1, 32'hDEADAAEF}) begin
      n_bad++;
      $display("FAIL bypass_off: got v=%b d=%h want 1/deadaaef", rdValidB, rdDataB);
    end
    issue_rd(4'd5);
    n_cmp++;
    if ({rdValidA, rdDataA} !== {1'b1, 32'h11ADAA44}) begin
      n_bad++;
      $display("FAIL bypass_after_A: got v=%b d=%h want 1/11adaa44", rdValidA, rdDataA);
    end
    cyc();
    n_cmp++;
    if ({rdValidB, rdDataB} !== {1'b1, 32'h11ADAA44}) begin
      n_bad++;
      $display("FAIL bypass_after_B: got v=%b d=%h want 1/11adaa44", rdValidB, rdDataB);
    end
  endtask

  task automatic test_diff_addr();
    wrReq = 1'b1; wrAddr = 4'd7; wrData = 32'hCAFEF00D; wrLane = 4'b1111;
    rdReq = 1'b1; rdAddr = 4'd5;
    cyc();
    idle();
    n_cmp++;
    if ({rdValidA, rdDataA} !== {1'b1, 32'h11ADAA44}) begin
      n_bad++;
      $display("FAIL diff_addr_A: got v=%b d=%h want 1/11adaa44", rdValidA, rdDataA);
    end
    cyc();
    issue_rd(4'd7);
    n_cmp++;
    if ({rdValidA, rdDataA} !== {1'b1, 32'hCAFEF00D}) begin
      n_bad++;
      $display("FAIL diff_addr_wr7: got v=%b d=%h want 1/cafef00d", rdValidA, rdDataA);
    end
    cyc();
  endtask

  task automatic test_read_then_write();
    rdReq = 1'b1; rdAddr = 4'd7;
    cyc();
    rdReq = 1'b0;
    wrReq = 1'b1; wrAddr = 4'd7; wrData = 32'h12345678; wrLane = 4'b1111;
    n_cmp++;
    if ({rdValidA, rdDataA} !== {1'b1, 32'hCAFEF00D}) begin
      n_bad++;
      $display("FAIL rd_then_wr_A: got v=%b d=%h want 1/cafef00d", rdValidA, rdDataA);
    end
    cyc();
    idle();
    n_cmp++;
    if ({rdValidB, rdDataB} !== {1'b1, 32'hCAFEF00D}) begin
      n_bad++;
      $display("FAIL rd_then_wr_B: got v=%b d=%h want 1/cafef00d", rdValidB, rdDataB);
    end
    issue_rd(4'd7);
    cyc();
    n_cmp++;
    if ({rdValidB, rdDataB} !== {1'b1, 32'h12345678}) begin
      n_bad++;
      $display("FAIL rd_then_wr_new: got v=%b d=%h want 1/12345678", rdValidB, rdDataB);
    end
  endtask

  task automatic test_back_to_back();
    logic        eva, evb;
    logic [31:0] eda, edb;
    wr(4'd1, 32'h1, 4'b1111);
    wr(4'd2, 32'h2, 4'b1111);
    wr(4'd3, 32'h3, 4'b1111);
    for (int i = 0; i < 6; i++) begin
      rdReq  = (i < 3);
      rdAddr = 4'(i + 1);
      cyc();
      eva = (i < 3);
      eda = (i < 3) ? 32'(i + 1) : 32'h3;
      evb = (i >= 1 && i <= 3);
      edb = (i == 0) ? 32'h12345678 : ((i <= 3) ? 32'(i) : 32'h3);
      n_cmp++;
      if ({rdValidA, rdDataA} !== {eva, eda}) begin
        n_bad++;
        $display("FAIL b2b_A[%0d]: got v=%b d=%h want v=%b d=%h", i, rdValidA, rdDataA, eva, eda);
      end
      n_cmp++;
      if ({rdValidB, rdDataB} !== {evb, edb}) begin
        n_bad++;
        $display("FAIL b2b_B[%0d]: got v=%b d=%h want v=%b d=%h", i, rdValidB, rdDataB, evb, edb);
      end
    end
    rdReq = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    reset = 1'b0;
    idle();
    cyc();
    reset = 1'b1;
    wrReq = 1'b1; wrAddr = 4'd3; wrData = 32'hFFFFFFFF; wrLane = 4'b1111;
    rdReq = 1'b1; rdAddr = 4'd3;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      n_cmp++;
      if ({readyA, rdValidA, rdValidB} !== 3'b000) begin
        n_bad++;
        $display("FAIL mid_clear[%0d]: got rdy=%b vA=%b vB=%b want 000", k, readyA, rdValidA, rdValidB);
      end
    end
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    n = 0;
    while (readyA !== 1'b1 && n < 40) begin
      cyc();
      n++;
      n_cmp++;
      if ({rdValidA, rdValidB} !== 2'b00) begin
        n_bad++;
        $display("FAIL reclear_valid[%0d]: got vA=%b vB=%b want 00", n, rdValidA, rdValidB);
      end
    end
    idle();
    n_cmp++;
    if (n !== 16) begin
      n_bad++;
      $display("FAIL reclear_cycles: got %0d want 16", n);
    end
    for (int i = 0; i < 16; i++) begin
      rdReq  = 1'b1;
      rdAddr = 4'(i);
      cyc();
      n_cmp++;
      if ({rdValidA, rdDataA} !== {1'b1, 32'h0}) begin
        n_bad++;
        $display("FAIL reclear_zero[%0d]: got v=%b d=%h want 1/0", i, rdValidA, rdDataA);
      end
    end
    rdReq = 1'b0;
    cyc();
    cyc();
    // read accepted at one edge, reset at the next: B must never report it
    issue_rd(4'd5);
    reset = 1'b0;
    cyc();
    n_cmp++;
    if ({readyA, rdValidA, readyB, rdValidB, rdDataB} !== 36'h0) begin
      n_bad++;
      $display("FAIL inflight_reset: got rdyA=%b vA=%b rdyB=%b vB=%b dB=%h want all zero",
               readyA, rdValidA, readyB, rdValidB, rdDataB);
    end
    reset = 1'b1;
    cyc();
    n_cmp++;
    if (rdValidB !== 1'b0) begin
      n_bad++;
      $display("FAIL inflight_after: got vB=%b want 0", rdValidB);
    end
    n = 0;
    while (readyA !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    rdReq = 1'b0; rdAddr = '0; wrReq = 1'b0; wrAddr = '0; wrData = '0; wrLane = '0;
    reset = 1'b0;
    test_reset();
    test_clear();
    test_full_write();
    test_partial_lanes();
    test_bypass();
    test_diff_addr();
    test_read_then_write();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/mips32_lane_ram.md
Name: mips32_lane_ram

Overview:
Next-generation byte-lane block RAM for the MIPS32 standalone system. It has one read port and one write port, with a valid/ready-style read path and a selectable 1- or 2-cycle read latency. A write-to-read bypass is optional. An optional post-reset clear engine zeroes the whole array before the RAM accepts traffic. It serves as the backing store for instruction/data memories where deterministic contents after reset are required.

Parameters:
AWIDTH, 10, address width; depth = 2^AWIDTH words.
DWIDTH, 32, data width; must be a multiple of 8 when LANES > 1.
LANES, 4, byte lanes; must be 1 (whole-word writes) or DWIDTH/8.
OUTREG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
CLEAR, 1, 1 = zero every word after reset; 0 = contents undefined, ready immediately.
BYPASS, 1, 1 = same-cycle read/write to the same address returns the new data; 0 = returns the old data.

Ports:
clock  in  1  sole clock; all state changes on its rising edge.
reset  in  1  synchronous, active-low reset.
ready  out  1  1 = requests accepted; 0 during reset and clear.
rdReq  in  1  read request, sampled when ready=1.
rdAddr  in  AWIDTH  read address.
rdData  out  DWIDTH  read data.
rdValid  out  1  1-cycle pulse marking rdData valid for one accepted read.
wrReq  in  1  write request, sampled when ready=1.
wrAddr  in  AWIDTH  write address.
wrData  in  DWIDTH  write data.
wrLane  in  LANES  byte-lane enables; bit i covers wrData[8i+7:8i]; ignored when LANES=1.

Behaviour:
- Reset (reset=0 at an edge):
  - state <= CLEAR if CLEAR=1, else RUN.
  - clear counter <= 0.
  - ready <= 0; rdValid <= 0; rdData <= 0.
  - All in-flight reads are discarded.
- State CLEAR:
  - Each cycle: writes all-zero (all lanes) to address = counter, then counter increments.
  - When the word at address 2^AWIDTH-1 is written: state <= RUN.
  - ready is 1 in the cycle after the last clear write, i.e. the first cycle after reset deasserts with ready=1 is cycle 2^AWIDTH.
  - rdReq/wrReq are ignored while ready=0; no queuing.
- State RUN: ready=1. It leaves RUN only via reset.
- CLEAR=0: state RUN from the first cycle after reset deasserts; ready=1 then.
- Reset asserted mid-clear: counter restarts at 0; the full clear is repeated.
- Write: wrReq & ready at edge N.
  - Enabled lanes of mem[wrAddr] are updated at edge N.
  - Disabled lanes are unchanged.
  - wrLane=0 with wrReq=1 is a legal no-op.
  - LANES=1: the whole word is written and wrLane is ignored.
- Read: rdReq & ready at edge N.
  - OUTREG=0: rdData = mem[rdAddr] and rdValid=1 during cycle N+1.
  - OUTREG=1: rdData = mem[rdAddr] and rdValid=1 during cycle N+2.
  - Fully pipelined: one read per cycle, results in issue order.
  - rdData holds its last value while rdValid=0.
- Same-address read and write in the same cycle:
  - BYPASS=1: the returned word has enabled lanes from wrData and the other lanes from old contents.
  - BYPASS=0: the returned word is the old contents.
- Different addresses in the same cycle: independent, no interaction.
- Writes after an accepted read do not alter that read's result; the result is sampled at issue (plus bypass).
- Addresses cover the full 2^AWIDTH range; there is no wrap or bounds check.
- Memory array: a plain reg array with per-lane write enables, so synthesis infers block RAM. Bypass muxing and the OUTREG stage sit outside the array.

Test Plan:
- Clear (AWIDTH=4, CLEAR=1): release reset -> ready=0 for exactly 16 cycles, then 1. Reading addresses 0..15 back-to-back -> 16 rdValid pulses, each rdData=0x00000000.
- Full write/read (OUTREG=0): write 0xDEADBEEF to addr 5 with wrLane=4'b1111; read addr 5 next cycle -> rdValid=1 one cycle after the request, rdData=0xDEADBEEF.
- Partial lanes: after the above, write 0x0000AA00 to addr 5 with wrLane=4'b0010, then read -> 0xDEADAAEF. Write with wrLane=0 then read -> still 0xDEADAAEF.
- Bypass: addr 5 holds 0xDEADAAEF; same cycle write 0x11223344 lanes 4'b1001 and read addr 5.
  - BYPASS=1 -> 0x11ADAA44.
  - BYPASS=0 -> 0xDEADAAEF; a following read -> 0x11ADAA44.
- OUTREG=1: reads of addrs 1,2,3 on consecutive cycles (holding 0x1,0x2,0x3) -> rdValid high for 3 consecutive cycles starting 2 cycles after the first request, data 0x1,0x2,0x3 in order.
- Reset mid-operation: assert reset for 1 cycle at clear cycle 7 -> ready rises 16 cycles after reset deasserts; rdReq/wrReq driven while ready=0 produce no rdValid and leave memory all-zero. Reset with a read in flight -> no rdValid for that read.
